// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX framer.
// Contents: FSM state encoding, GMII preamble/SFD byte values and CRC-32
// constants (reflected polynomial, initial value, receiver residue).
// ETH_TX_MINPAD_EN adds the PAD state to the state encoding.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
`ifdef ETH_TX_MINPAD_EN
        ST_PAD,
`endif
        ST_FCS,
        ST_IFG
    } eth_state_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide combinational CRC-32 step (reflected polynomial, data LSB first).
// Ports:
//   crc_in  [31:0]  running CRC before this byte
//   data    [7:0]   byte to fold in
//   crc_out [31:0]  running CRC after this byte
module eth_crc32
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: takes DA|SA|LEN|payload bytes over valid/ready/sop/eop
// and drives GMII TX with preamble, SFD, optional zero padding, FCS and IFG.
// Optional feature macro: ETH_TX_MINPAD_EN (pad short frames to MIN_FRAME).
// Ports:
//   i_clk125      byte clock
//   i_rst_n       async active-low reset
//   i_dval/i_data/i_sop/i_eop  upstream byte stream
//   o_rdy         byte accepted when i_dval & o_rdy
//   o_txd/o_tx_en/o_tx_er      GMII transmit
//   o_frame_done  pulse with the last FCS byte on o_txd
//   o_underrun    pulse on mid-frame starvation (same cycle as o_tx_er)
//
// state | meaning
// IDLE  | wire idle; non-sop bytes are swallowed, sop starts a frame
// PRE   | 0x55 on the wire, PREAMBLE_BYTES cycles
// SFD   | 0xD5 on the wire; sop byte is accepted here
// DATA  | previously accepted byte on the wire; next byte accepted
// PAD   | zero bytes until MIN_FRAME reached (ETH_TX_MINPAD_EN only)
// FCS   | complemented CRC bytes, LSB byte first
// IFG   | tx_en low for IFG_BYTES cycles
//
// The state names what is on the wire this cycle, so output registers are
// loaded from the next-state logic. Data goes one cycle behind acceptance,
// which is why PAD/FCS begin while the last data byte is still on the wire.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
`ifdef ETH_TX_MINPAD_EN
  , parameter int MIN_FRAME      = 60
`endif
) (
    input  logic       i_clk125,
    input  logic       i_rst_n,
    input  logic       i_dval,
    input  logic [7:0] i_data,
    input  logic       i_sop,
    input  logic       i_eop,
    output logic       o_rdy,
    output logic [7:0] o_txd,
    output logic       o_tx_en,
    output logic       o_tx_er,
    output logic       o_frame_done,
    output logic       o_underrun
);

    localparam int TMR_SPAN = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
    localparam int TMR_W    = (TMR_SPAN > 4) ? $clog2(TMR_SPAN) : 2;
    localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(PREAMBLE_BYTES - 1);
    localparam logic [TMR_W-1:0] IFG_LOAD = TMR_W'(IFG_BYTES - 1);
    localparam logic [TMR_W-1:0] FCS_LOAD = TMR_W'(3);

    eth_state_t       state_q, state_nx;
    logic [TMR_W-1:0] tmr_q, tmr_nx;
    logic [31:0]      crc_q, crc_nx, crc_calc;
    logic [7:0]       crc_byte;
    logic [7:0]       txd_nx;
    logic             tx_en_nx, tx_er_nx, done_nx, urun_nx, rdy_nx;
    logic             rdy_q, alive_q;

`ifdef ETH_TX_MINPAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
    logic [10:0] cnt_q, cnt_nx, cnt_inc;
    // Saturating byte count; frames beyond 2047 bytes are not checked.
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
`endif

    eth_crc32 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_calc)
    );

    // alive_q keeps ready low while reset is held, since the IDLE term
    // depends directly on the upstream inputs.
    assign o_rdy = rdy_q | (alive_q & (state_q == ST_IDLE) & i_dval & ~i_sop);

    always_comb begin
        state_nx = state_q;
        tmr_nx   = tmr_q;
        crc_nx   = crc_q;
        crc_byte = i_data;
        txd_nx   = 8'h00;
        tx_en_nx = 1'b0;
        tx_er_nx = 1'b0;
        done_nx  = 1'b0;
        urun_nx  = 1'b0;
        rdy_nx   = 1'b0;
`ifdef ETH_TX_MINPAD_EN
        cnt_nx   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                crc_nx = CRC_INIT;
`ifdef ETH_TX_MINPAD_EN
                cnt_nx = '0;
`endif
                if (i_dval && i_sop) begin
                    state_nx = ST_PRE;
                    tmr_nx   = PRE_LOAD;
                    txd_nx   = ETH_PREAMBLE;
                    tx_en_nx = 1'b1;
                end
            end
            ST_PRE: begin
                txd_nx   = ETH_PREAMBLE;
                tx_en_nx = 1'b1;
                if (tmr_q == '0) begin
                    state_nx = ST_SFD;
                    txd_nx   = ETH_SFD;
                    rdy_nx   = 1'b1;
                end else begin
                    tmr_nx = tmr_q - 1'b1;
                end
            end
            ST_SFD, ST_DATA: begin
                tx_en_nx = 1'b1;
                if (i_dval) begin
                    txd_nx = i_data;
                    crc_nx = crc_calc;
`ifdef ETH_TX_MINPAD_EN
                    cnt_nx = cnt_inc;
`endif
                    if (i_eop) begin
                        tmr_nx = FCS_LOAD;
`ifdef ETH_TX_MINPAD_EN
                        state_nx = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
`else
                        state_nx = ST_FCS;
`endif
                    end else begin
                        state_nx = ST_DATA;
                        rdy_nx   = 1'b1;
                    end
                end else begin
                    // Starved mid-frame: one error byte, then straight to IFG.
                    tx_er_nx = 1'b1;
                    urun_nx  = 1'b1;
                    state_nx = ST_IFG;
                    tmr_nx   = IFG_LOAD;
                end
            end
`ifdef ETH_TX_MINPAD_EN
            ST_PAD: begin
                crc_byte = 8'h00;
                crc_nx   = crc_calc;
                tx_en_nx = 1'b1;
                cnt_nx   = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    state_nx = ST_FCS;
                    tmr_nx   = FCS_LOAD;
                end
            end
`endif
            ST_FCS: begin
                tx_en_nx = 1'b1;
                case (tmr_q[1:0])
                    2'd3:    txd_nx = ~crc_q[7:0];
                    2'd2:    txd_nx = ~crc_q[15:8];
                    2'd1:    txd_nx = ~crc_q[23:16];
                    default: txd_nx = ~crc_q[31:24];
                endcase
                if (tmr_q == '0) begin
                    done_nx  = 1'b1;
                    state_nx = ST_IFG;
                    tmr_nx   = IFG_LOAD;
                end else begin
                    tmr_nx = tmr_q - 1'b1;
                end
            end
            ST_IFG: begin
                if (tmr_q == '0) state_nx = ST_IDLE;
                else             tmr_nx   = tmr_q - 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk125 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            crc_q        <= '0;
            rdy_q        <= 1'b0;
            alive_q      <= 1'b0;
            o_txd        <= 8'h00;
            o_tx_en      <= 1'b0;
            o_tx_er      <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
`ifdef ETH_TX_MINPAD_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_nx;
            tmr_q        <= tmr_nx;
            crc_q        <= crc_nx;
            rdy_q        <= rdy_nx;
            alive_q      <= 1'b1;
            o_txd        <= txd_nx;
            o_tx_en      <= tx_en_nx;
            o_tx_er      <= tx_er_nx;
            o_frame_done <= done_nx;
            o_underrun   <= urun_nx;
`ifdef ETH_TX_MINPAD_EN
            cnt_q        <= cnt_nx;
`endif
        end
    end

endmodule
